// File: rtl/pc_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode
// handoff, and the resolved branch/jump redirect inputs.
interface pc_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_pc;
  logic [ADDR_W-1:0]  branch_offset;
  logic               jump;
  logic [ADDR_W-1:0]  jump_target;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  branch_taken, branch_pc, branch_offset, jump, jump_target
  );

  // Environment side: instruction memory, decode and branch resolution
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output branch_taken, branch_pc, branch_offset, jump, jump_target
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer. Issues one memory
// request at a time, presents the returned instruction to decode, and
// redirects on a taken branch or jump, discarding any stale response.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               drop_q;
  logic               req_valid_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic               instr_valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;

  logic               redir;
  logic [ADDR_W-1:0]  br_tgt;
  logic [ADDR_W-1:0]  tgt_raw;
  logic [ADDR_W-1:0]  redir_tgt;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  next_req_pc;

  // Redirect target selection; jump outranks branch, result word aligned
  always_comb begin
    redir       = bus.jump | bus.branch_taken;
    br_tgt      = bus.branch_pc + ADDR_W'(4) + (bus.branch_offset << 2);
    tgt_raw     = bus.jump ? bus.jump_target : br_tgt;
    redir_tgt   = {tgt_raw[ADDR_W-1:2], 2'b00};
    pc_inc      = pc_q + ADDR_W'(4);
    next_req_pc = redir ? redir_tgt : pc_q;
  end

  // Fetch FSM with registered request and decode-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      if (redir) pc_q <= redir_tgt;
      case (state_q)
        IDLE: begin
          state_q     <= REQ;
          req_valid_q <= 1'b1;
          req_addr_q  <= next_req_pc;
        end
        REQ: begin
          // The outstanding address is never changed before acceptance;
          // a redirect here only marks the eventual response as stale.
          if (bus.imem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
          if (redir) drop_q <= 1'b1;
        end
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (drop_q || redir) begin
              drop_q      <= 1'b0;
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= next_req_pc;
            end else begin
              instr_q       <= bus.imem_rsp_data;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              pc_q          <= pc_inc;
              state_q       <= HOLD;
            end
          end else if (redir) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          // A redirect flushes the held instruction even if decode is ready
          if (redir || bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= REQ;
            req_valid_q   <= 1'b1;
            req_addr_q    <= next_req_pc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = req_addr_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;

endmodule
